// File: rtl/mp_dsc_fetch_mgr.sv
`default_nettype none
// ============================================================================
// mp_dsc_fetch_mgr : queues process jobs, fetches descriptor bursts over AXI,
//                    follows chains and steers beats to per-channel FIFOs
// Revision         : 1.0
// ============================================================================
module mp_dsc_fetch_mgr #(
  parameter int                     DATA_WIDTH = 1024,
  parameter int                     ADDR_WIDTH = 64,
  parameter int                     ID_WIDTH   = 1,
  parameter int                     PID_WIDTH  = 9,
  parameter int                     NUM_CH     = 2,
  parameter int                     JOB_DEPTH  = 16,
  parameter int                     DSC_DEPTH  = 64,
  parameter logic [ID_WIDTH-1:0]    ARID_VAL   = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ADDR_WIDTH+PID_WIDTH+7:0]  job_info_i,
  input  logic                             job_valid_i,
  output logic                             job_ready_o,
  input  logic [NUM_CH-1:0]                dsc_pull_i,
  output logic [NUM_CH-1:0]                dsc_valid_o,
  output logic [NUM_CH*DATA_WIDTH-1:0]     dsc_data_o,
  output logic                             err_o,
  output logic [PID_WIDTH-1:0]             err_pid_o,
  input  logic                             err_clr_i,
  output logic [ID_WIDTH-1:0]              m_axi_arid,
  output logic [ADDR_WIDTH-1:0]            m_axi_araddr,
  output logic [7:0]                       m_axi_arlen,
  output logic [2:0]                       m_axi_arsize,
  output logic [1:0]                       m_axi_arburst,
  output logic                             m_axi_arlock,
  output logic [3:0]                       m_axi_arcache,
  output logic [2:0]                       m_axi_arprot,
  output logic [3:0]                       m_axi_arqos,
  output logic [3:0]                       m_axi_arregion,
  output logic [PID_WIDTH-1:0]             m_axi_aruser,
  output logic                             m_axi_arvalid,
  input  logic                             m_axi_arready,
  input  logic [ID_WIDTH-1:0]              m_axi_rid,
  input  logic [DATA_WIDTH-1:0]            m_axi_rdata,
  input  logic [1:0]                       m_axi_rresp,
  input  logic                             m_axi_rlast,
  input  logic                             m_axi_rvalid,
  output logic                             m_axi_rready
);

  localparam int JW     = ADDR_WIDTH + PID_WIDTH + 8;
  localparam int JAW    = $clog2(JOB_DEPTH);
  localparam int DAW    = $clog2(DSC_DEPTH);
  localparam int CW     = DAW + 2;
  localparam int NW     = (CW > 9) ? CW : 9;
  localparam int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ARSIZE = $clog2(DATA_WIDTH / 8);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADDR = 2'd1, S_DATA = 2'd2} state_t;

  function automatic logic [CHW-1:0] ch_of(input logic [PID_WIDTH-1:0] p);
    return CHW'(p % NUM_CH);
  endfunction

  state_t                 state;
  logic                   out_of_rst;
  logic                   burst_bad;
  logic                   chain_pend;
  logic [JW-1:0]          chain_job;
  logic [CW-1:0]          reserved [NUM_CH];
  logic [DAW:0]           fifo_cnt [NUM_CH];
  logic [CW-1:0]          credit   [NUM_CH];

  // Job queue
  logic [JW-1:0]          job_mem [JOB_DEPTH];
  logic [JAW-1:0]         jq_wr;
  logic [JAW-1:0]         jq_rd;
  logic [JAW:0]           jq_cnt;
  logic                   host_push;
  logic                   jq_push;
  logic                   jq_pop;
  logic [JW-1:0]          jq_wdata;

  logic [JW-1:0]          head;
  logic [7:0]             head_len;
  logic [PID_WIDTH-1:0]   head_pid;
  logic [ADDR_WIDTH-1:0]  head_addr;
  logic [CHW-1:0]         head_ch;
  logic [NW-1:0]          head_need;
  logic                   head_big;
  logic                   start;
  logic                   drop;

  logic [CHW-1:0]         cur_ch;
  logic                   beat;
  logic                   beat_bad;
  logic                   beat_push;
  logic                   new_err;
  logic [PID_WIDTH-1:0]   err_src;
  logic [63:0]            next_addr;
  logic [DATA_WIDTH-1:0]  push_data;

  // One queue slot is held back so a chained job always finds room.
  assign job_ready_o = out_of_rst & (jq_cnt < (JAW+1)'(JOB_DEPTH - 1)) & ~chain_pend;
  assign host_push   = job_valid_i & job_ready_o;
  assign jq_push     = host_push | chain_pend;
  assign jq_wdata    = chain_pend ? chain_job : job_info_i;

  assign head      = job_mem[jq_rd];
  assign head_len  = head[JW-1 -: 8];
  assign head_pid  = head[ADDR_WIDTH +: PID_WIDTH];
  assign head_addr = head[ADDR_WIDTH-1:0];
  assign head_ch   = ch_of(head_pid);
  assign head_need = NW'(head_len) + NW'(1);
  assign head_big  = head_need > NW'(DSC_DEPTH);
  assign start     = (state == S_IDLE) & (jq_cnt != '0) & ~head_big &
                     (NW'(credit[head_ch]) >= head_need);
  assign drop      = (state == S_IDLE) & (jq_cnt != '0) & head_big;
  assign jq_pop    = drop | ((state == S_ADDR) & m_axi_arready);

  assign cur_ch    = ch_of(m_axi_aruser);
  assign beat      = (state == S_DATA) & m_axi_rvalid & (m_axi_rid == ARID_VAL);
  assign beat_bad  = beat & ((m_axi_rresp != 2'b00) | burst_bad);
  assign beat_push = beat & ~beat_bad;
  assign new_err   = drop | (beat & (m_axi_rresp != 2'b00) & ~burst_bad);
  assign err_src   = drop ? head_pid : m_axi_aruser;
  assign next_addr = m_axi_rdata[DATA_WIDTH-1 -: 64];
  assign push_data = {64'(m_axi_aruser), m_axi_rdata[DATA_WIDTH-65:0]};

  assign m_axi_arid     = ARID_VAL;
  assign m_axi_arsize   = 3'(ARSIZE);
  assign m_axi_arburst  = 2'b01;
  assign m_axi_arlock   = 1'b0;
  assign m_axi_arcache  = 4'b0011;
  assign m_axi_arprot   = 3'b000;
  assign m_axi_arqos    = 4'b0000;
  assign m_axi_arregion = 4'b0000;
  assign m_axi_rready   = 1'b1;

  always_ff @(posedge clk) begin
    if (jq_push) job_mem[jq_wr] <= jq_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jq_wr      <= '0;
      jq_rd      <= '0;
      jq_cnt     <= '0;
      out_of_rst <= 1'b0;
    end else begin
      out_of_rst <= 1'b1;
      if (jq_push) jq_wr <= jq_wr + JAW'(1);
      if (jq_pop)  jq_rd <= jq_rd + JAW'(1);
      case ({jq_push, jq_pop})
        2'b10:   jq_cnt <= jq_cnt + (JAW+1)'(1);
        2'b01:   jq_cnt <= jq_cnt - (JAW+1)'(1);
        default: jq_cnt <= jq_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_aruser  <= '0;
      burst_bad     <= 1'b0;
      chain_pend    <= 1'b0;
      chain_job     <= '0;
      err_o         <= 1'b0;
      err_pid_o     <= '0;
      for (int c = 0; c < NUM_CH; c++) reserved[c] <= '0;
    end else begin
      chain_pend <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            m_axi_arvalid <= 1'b1;
            m_axi_araddr  <= head_addr;
            m_axi_arlen   <= head_len;
            m_axi_aruser  <= head_pid;
            state         <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid    <= 1'b0;
            reserved[cur_ch] <= reserved[cur_ch] + CW'(m_axi_arlen) + CW'(1);
            burst_bad        <= 1'b0;
            state            <= S_DATA;
          end
        end
        S_DATA: begin
          if (beat) begin
            reserved[cur_ch] <= reserved[cur_ch] - CW'(1);
            if (m_axi_rresp != 2'b00) burst_bad <= 1'b1;
            if (m_axi_rlast) begin
              state <= S_IDLE;
              if (beat_push && (next_addr != 64'd0)) begin
                chain_pend <= 1'b1;
                chain_job  <= {m_axi_rdata[15:8], m_axi_aruser, ADDR_WIDTH'(next_addr)};
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
      // A fresh error outranks a clear issued in the same cycle.
      if (new_err) begin
        err_o <= 1'b1;
        if (!err_o || err_clr_i) err_pid_o <= err_src;
      end else if (err_clr_i) begin
        err_o <= 1'b0;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_WIDTH-1:0] mem [DSC_DEPTH];
    logic [DAW-1:0]        wr;
    logic [DAW-1:0]        rd;
    logic [DAW:0]          cnt;
    logic                  push;
    logic                  pop;

    assign push = beat_push & (cur_ch == CHW'(c));
    assign pop  = dsc_pull_i[c] & (cnt != '0);

    always_ff @(posedge clk) begin
      if (push) mem[wr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr  <= '0;
        rd  <= '0;
        cnt <= '0;
      end else begin
        if (push) wr <= wr + DAW'(1);
        if (pop)  rd <= rd + DAW'(1);
        case ({push, pop})
          2'b10:   cnt <= cnt + (DAW+1)'(1);
          2'b01:   cnt <= cnt - (DAW+1)'(1);
          default: cnt <= cnt;
        endcase
      end
    end

    assign fifo_cnt[c]                           = cnt;
    assign credit[c]                             = CW'(DSC_DEPTH) - CW'(cnt) - reserved[c];
    assign dsc_valid_o[c]                        = (cnt != '0);
    assign dsc_data_o[c*DATA_WIDTH +: DATA_WIDTH] = mem[rd];
  end

endmodule
`default_nettype wire

// File: tb/tb_mp_dsc_fetch_mgr.sv
`default_nettype none
// ============================================================================
// tb_mp_dsc_fetch_mgr : directed self-checking bench for mp_dsc_fetch_mgr
// Revision            : 1.0
// ============================================================================
module tb_mp_dsc_fetch_mgr;
  localparam int DW = 128, AW = 64, IW = 1, PW = 9, NCH = 2, JD = 16, DD = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [AW+PW+7:0]  job_info = '0;
  logic              job_valid = 1'b0;
  logic              job_ready;
  logic [NCH-1:0]    dsc_pull = '0;
  logic [NCH-1:0]    dsc_valid;
  logic [NCH*DW-1:0] dsc_data;
  logic              err;
  logic [PW-1:0]     err_pid;
  logic              err_clr = 1'b0;
  logic [IW-1:0]     arid;
  logic [AW-1:0]     araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arqos;
  logic [3:0]        arregion;
  logic [PW-1:0]     aruser;
  logic              arvalid;
  logic              arready = 1'b0;
  logic [IW-1:0]     rid = '0;
  logic [DW-1:0]     rdata = '0;
  logic [1:0]        rresp = '0;
  logic              rlast = 1'b0;
  logic              rvalid = 1'b0;
  logic              rready;

  mp_dsc_fetch_mgr #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .PID_WIDTH(PW),
    .NUM_CH(NCH), .JOB_DEPTH(JD), .DSC_DEPTH(DD), .ARID_VAL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .job_info_i(job_info), .job_valid_i(job_valid), .job_ready_o(job_ready),
    .dsc_pull_i(dsc_pull), .dsc_valid_o(dsc_valid), .dsc_data_o(dsc_data),
    .err_o(err), .err_pid_o(err_pid), .err_clr_i(err_clr),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
    .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arlock(arlock),
    .m_axi_arcache(arcache), .m_axi_arprot(arprot), .m_axi_arqos(arqos),
    .m_axi_arregion(arregion), .m_axi_aruser(aruser), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready), .m_axi_rid(rid), .m_axi_rdata(rdata),
    .m_axi_rresp(rresp), .m_axi_rlast(rlast), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] beat_low(input int i, input logic [7:0] nlen);
    return {40'hA5A5A5A5A5, 8'(i), nlen, 8'hC3};
  endfunction

  task automatic push_job(input logic [63:0] addr, input logic [8:0] pid, input logic [7:0] len);
    job_info  = {len, pid, addr};
    job_valid = 1'b1;
    for (int k = 0; k < 50 && !job_ready; k++) tick();
    chk("job_ready", job_ready, 1'b1);
    tick();
    job_valid = 1'b0;
  endtask

  task automatic wait_ar(input logic [63:0] addr, input logic [8:0] pid, input logic [7:0] len,
                         input string tag);
    for (int k = 0; k < 100 && !arvalid; k++) tick();
    chk({tag, "_arvalid"}, arvalid, 1'b1);
    chk({tag, "_araddr"}, araddr, addr);
    chk({tag, "_arlen"}, arlen, len);
    chk({tag, "_aruser"}, aruser, pid);
    tick();
    chk({tag, "_ar_hold"}, {arvalid, araddr}, {1'b1, addr});
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk({tag, "_ar_drop"}, arvalid, 1'b0);
  endtask

  task automatic send_burst(input int n, input int bad, input logic [63:0] nxt, input logic [7:0] nlen);
    for (int i = 0; i < n; i++) begin
      rvalid = 1'b1;
      rid    = '0;
      rresp  = (i == bad) ? 2'd2 : 2'd0;
      rlast  = (i == n - 1);
      rdata  = {(i == n - 1) ? nxt : (64'hFEED000000000000 | 64'(i)), beat_low(i, nlen)};
      tick();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = '0;
  endtask

  task automatic pop(input int ch, input logic [8:0] pid, input logic [63:0] low, input string tag);
    chk({tag, "_valid"}, dsc_valid[ch], 1'b1);
    chk({tag, "_data"}, dsc_data[ch*DW +: DW], {64'(pid), low});
    dsc_pull[ch] = 1'b1;
    tick();
    dsc_pull = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", job_ready, 1'b0);
    chk("rst_valid", dsc_valid, 2'b00);
    chk("rst_err", {err, err_pid}, '0);
    chk("rst_arvalid", arvalid, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", job_ready, 1'b1);
    chk("ar_consts", {arid, arsize, arburst, arcache, arlock, arprot, arqos, arregion, rready},
        {1'b0, 3'd4, 2'b01, 4'd3, 1'b0, 3'd0, 4'd0, 4'd0, 1'b1});

    // Single job, pid 5 -> channel 1
    push_job(64'h1000, 9'd5, 8'd3);
    wait_ar(64'h1000, 9'd5, 8'd3, "s1");
    send_burst(4, 99, 64'h0, 8'd0);
    chk("s1_valid", dsc_valid, 2'b10);
    for (int i = 0; i < 4; i++) pop(1, 9'd5, beat_low(i, 8'd0), "s1_pop");
    chk("s1_empty", dsc_valid, 2'b00);
    repeat (5) tick();
    chk("s1_no_ar", arvalid, 1'b0);

    // Chain to 0x2000 with arlen 1
    push_job(64'h3000, 9'd7, 8'd3);
    wait_ar(64'h3000, 9'd7, 8'd3, "s2a");
    send_burst(4, 99, 64'h2000, 8'd1);
    wait_ar(64'h2000, 9'd7, 8'd1, "s2b");
    send_burst(2, 99, 64'h0, 8'd0);
    for (int i = 0; i < 4; i++) pop(1, 9'd7, beat_low(i, 8'd1), "s2_pop_a");
    for (int i = 0; i < 2; i++) pop(1, 9'd7, beat_low(i, 8'd0), "s2_pop_b");
    chk("s2_empty", dsc_valid, 2'b00);
    repeat (4) tick();
    chk("s2_no_ar", arvalid, 1'b0);

    // Credit stall: 62 entries on channel 0, next job needs 4
    push_job(64'h4000, 9'd2, 8'd61);
    wait_ar(64'h4000, 9'd2, 8'd61, "s3a");
    send_burst(62, 99, 64'h0, 8'd0);
    push_job(64'h5000, 9'd4, 8'd3);
    repeat (4) tick();
    chk("s3_stall", arvalid, 1'b0);
    pop(0, 9'd2, beat_low(0, 8'd0), "s3_pop");
    pop(0, 9'd2, beat_low(1, 8'd0), "s3_pop");
    chk("s3_still_stall", arvalid, 1'b0);
    tick();
    chk("s3_release", arvalid, 1'b1);
    wait_ar(64'h5000, 9'd4, 8'd3, "s3b");
    send_burst(4, 99, 64'h0, 8'd0);
    for (int i = 2; i < 62; i++) pop(0, 9'd2, beat_low(i, 8'd0), "s3_drain");
    for (int i = 0; i < 4; i++) pop(0, 9'd4, beat_low(i, 8'd0), "s3_drain_b");
    chk("s3_empty", dsc_valid, 2'b00);

    // Error on beat 1: only beat 0 kept, no chain
    push_job(64'h6000, 9'd3, 8'd3);
    wait_ar(64'h6000, 9'd3, 8'd3, "s4");
    send_burst(4, 1, 64'h7000, 8'd0);
    chk("s4_valid", dsc_valid, 2'b10);
    chk("s4_err", err, 1'b1);
    chk("s4_err_pid", err_pid, 9'd3);
    pop(1, 9'd3, beat_low(0, 8'd0), "s4_pop");
    chk("s4_empty", dsc_valid, 2'b00);
    repeat (4) tick();
    chk("s4_no_chain", arvalid, 1'b0);
    // A full-depth burst on channel 1 only issues if all credit came back
    push_job(64'hC000, 9'd1, 8'd63);
    wait_ar(64'hC000, 9'd1, 8'd63, "s4_credit");
    send_burst(64, 99, 64'h0, 8'd0);
    chk("s4_full_head", dsc_data[DW +: DW], {64'd1, beat_low(0, 8'd0)});
    dsc_pull[1] = 1'b1;
    repeat (64) tick();
    dsc_pull = '0;
    chk("s4_full_drained", dsc_valid, 2'b00);
    // Oversized job is dropped; its error coincides with a clear and wins
    push_job(64'hD000, 9'd6, 8'd64);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("s4_big_err", {err, err_pid}, {1'b1, 9'd6});
    repeat (3) tick();
    chk("s4_big_no_ar", arvalid, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("s4_clr", err, 1'b0);

    // Host job collides with the rlast of a chaining burst
    push_job(64'h8000, 9'd9, 8'd1);
    wait_ar(64'h8000, 9'd9, 8'd1, "s5");
    rvalid = 1'b1; rresp = 2'd0; rlast = 1'b0;
    rdata  = {64'hFEED000000000000, beat_low(0, 8'd0)};
    tick();
    rlast     = 1'b1;
    rdata     = {64'h9000, beat_low(1, 8'd0)};
    job_info  = {8'd0, 9'd11, 64'hA000};
    job_valid = 1'b1;
    chk("s5_ready_at_last", job_ready, 1'b1);
    tick();
    rvalid = 1'b0; rlast = 1'b0; job_valid = 1'b0;
    chk("s5_ready_low", job_ready, 1'b0);
    tick();
    chk("s5_ready_back", job_ready, 1'b1);
    wait_ar(64'hA000, 9'd11, 8'd0, "s5_host");
    send_burst(1, 99, 64'h0, 8'd0);
    wait_ar(64'h9000, 9'd9, 8'd0, "s5_chain");
    send_burst(1, 99, 64'h0, 8'd0);
    pop(1, 9'd9, beat_low(0, 8'd0), "s5_pop");
    pop(1, 9'd9, beat_low(1, 8'd0), "s5_pop");
    pop(1, 9'd11, beat_low(0, 8'd0), "s5_pop_host");
    pop(1, 9'd9, beat_low(0, 8'd0), "s5_pop_chain");
    chk("s5_empty", dsc_valid, 2'b00);

    // Make err_pid non-zero so the reset check below is meaningful
    push_job(64'hE000, 9'd13, 8'd100);
    repeat (3) tick();
    chk("s6_pre_err", {err, err_pid}, {1'b1, 9'd13});

    // Reset in the middle of a burst
    push_job(64'hB000, 9'd1, 8'd3);
    wait_ar(64'hB000, 9'd1, 8'd3, "s6");
    for (int i = 0; i < 2; i++) begin
      rvalid = 1'b1; rresp = 2'd0; rlast = 1'b0;
      rdata  = {64'hFEED000000000000, beat_low(i, 8'd0)};
      tick();
    end
    rvalid = 1'b0;
    chk("s6_pre_valid", dsc_valid, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_valid", dsc_valid, 2'b00);
    chk("s6_rst_ar", arvalid, 1'b0);
    chk("s6_rst_ready", job_ready, 1'b0);
    chk("s6_rst_err", {err, err_pid}, '0);
    tick();
    rst_n = 1'b1;
    for (int i = 2; i < 4; i++) begin
      rvalid = 1'b1; rresp = 2'd0; rlast = (i == 3);
      rdata  = {(i == 3) ? 64'h1234 : 64'hFEED000000000000, beat_low(i, 8'd0)};
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0;
    tick();
    chk("s6_no_push", dsc_valid, 2'b00);
    chk("s6_no_ar", arvalid, 1'b0);
    chk("s6_ready", job_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
